// File: rtl/rd_decoder_8b10b.sv
// 8b/10b receive decoder: 10-bit code group in, byte + K flag out, with
// independent running-disparity tracking and code/disparity error flags.
module rd_decoder_8b10b #(
    parameter int WIDTH  = 10,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startin,
    input  logic              pushin,
    input  logic [WIDTH-1:0]  datain,
    output logic              pushout,
    output logic [DWIDTH-1:0] dataout,
    output logic              kout,
    output logic              codeErr,
    output logic              dispErr,
    output logic              RDout
);

    typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_state_t;

    rd_state_t rd_reg, rd_next, rd_in, rd_mid, rd_word;

    logic [5:0] sb6;
    logic [3:0] sb4, sb4_norm;
    logic [4:0] x5;
    logic [2:0] y3;
    logic [2:0] ones6, ones4;
    logic [3:0] ones_total;
    logic       v6, v4, k28, a7, xk7, xa7;
    logic       err6, err4, code_err, k_flag;

    always_comb begin
        sb6 = datain[9:4];
        sb4 = datain[3:0];
        v6  = 1'b1;
        k28 = 1'b0;
        x5  = 5'd0;
        case (sb6)
            6'b100111, 6'b011000: x5 = 5'd0;
            6'b011101, 6'b100010: x5 = 5'd1;
            6'b101101, 6'b010010: x5 = 5'd2;
            6'b110001:            x5 = 5'd3;
            6'b110101, 6'b001010: x5 = 5'd4;
            6'b101001:            x5 = 5'd5;
            6'b011001:            x5 = 5'd6;
            6'b111000, 6'b000111: x5 = 5'd7;
            6'b111001, 6'b000110: x5 = 5'd8;
            6'b100101:            x5 = 5'd9;
            6'b010101:            x5 = 5'd10;
            6'b110100:            x5 = 5'd11;
            6'b001101:            x5 = 5'd12;
            6'b101100:            x5 = 5'd13;
            6'b011100:            x5 = 5'd14;
            6'b010111, 6'b101000: x5 = 5'd15;
            6'b011011, 6'b100100: x5 = 5'd16;
            6'b100011:            x5 = 5'd17;
            6'b010011:            x5 = 5'd18;
            6'b110010:            x5 = 5'd19;
            6'b001011:            x5 = 5'd20;
            6'b101010:            x5 = 5'd21;
            6'b011010:            x5 = 5'd22;
            6'b111010, 6'b000101: x5 = 5'd23;
            6'b110011, 6'b001100: x5 = 5'd24;
            6'b100110:            x5 = 5'd25;
            6'b010110:            x5 = 5'd26;
            6'b110110, 6'b001001: x5 = 5'd27;
            6'b001110:            x5 = 5'd28;
            6'b101110, 6'b010001: x5 = 5'd29;
            6'b011110, 6'b100001: x5 = 5'd30;
            6'b101011, 6'b010100: x5 = 5'd31;
            6'b001111, 6'b110000: begin x5 = 5'd28; k28 = 1'b1; end
            default:              v6 = 1'b0;
        endcase

        // The RD+ form of K28 carries the bit-inverted 4b sub-block.
        sb4_norm = (sb6 == 6'b110000) ? ~sb4 : sb4;
        v4 = 1'b1;
        a7 = 1'b0;
        y3 = 3'd0;
        case (sb4_norm)
            4'b1011, 4'b0100: y3 = 3'd0;
            4'b1001:          y3 = 3'd1;
            4'b0101:          y3 = 3'd2;
            4'b1100, 4'b0011: y3 = 3'd3;
            4'b1101, 4'b0010: y3 = 3'd4;
            4'b1010:          y3 = 3'd5;
            4'b0110:          y3 = 3'd6;
            4'b1110, 4'b0001: y3 = 3'd7;
            4'b0111, 4'b1000: begin y3 = 3'd7; a7 = 1'b1; end
            default:          v4 = 1'b0;
        endcase

        xk7 = (x5 == 5'd23) || (x5 == 5'd27) || (x5 == 5'd29) || (x5 == 5'd30);
        xa7 = (x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20) ||
              (x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14);

        ones6      = 3'($countones(sb6));
        ones4      = 3'($countones(sb4));
        ones_total = {1'b0, ones6} + {1'b0, ones4};

        code_err = !v6 || !v4 ||
                   (ones6 < 3'd2) || (ones6 > 3'd4) ||
                   (ones4 == 3'd0) || (ones4 == 3'd4) ||
                   (ones_total < 4'd4) || (ones_total > 4'd6) ||
                   (a7 && !k28 && !xk7 && !xa7);
        k_flag = k28 || (xk7 && a7);

        rd_in = startin ? RD_NEG : rd_reg;

        err6   = 1'b0;
        rd_mid = rd_in;
        if (ones6 == 3'd4) begin
            err6   = (rd_in == RD_POS);
            rd_mid = RD_POS;
        end else if (ones6 == 3'd2) begin
            err6   = (rd_in == RD_NEG);
            rd_mid = RD_NEG;
        end else if (sb6 == 6'b000111) begin
            err6   = (rd_in == RD_NEG);
            rd_mid = RD_POS;
        end else if (sb6 == 6'b111000) begin
            err6   = (rd_in == RD_POS);
            rd_mid = RD_NEG;
        end

        err4    = 1'b0;
        rd_word = rd_mid;
        if (ones4 == 3'd3) begin
            err4    = (rd_mid == RD_POS);
            rd_word = RD_POS;
        end else if (ones4 == 3'd1) begin
            err4    = (rd_mid == RD_NEG);
            rd_word = RD_NEG;
        end else if (sb4 == 4'b0011) begin
            err4    = (rd_mid == RD_NEG);
            rd_word = RD_POS;
        end else if (sb4 == 4'b1100) begin
            err4    = (rd_mid == RD_POS);
            rd_word = RD_NEG;
        end

        rd_next = rd_in;
        if (pushin && !code_err) begin
            rd_next = rd_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_reg  <= RD_NEG;
            pushout <= 1'b0;
            dataout <= '0;
            kout    <= 1'b0;
            codeErr <= 1'b0;
            dispErr <= 1'b0;
        end else begin
            rd_reg  <= rd_next;
            pushout <= pushin;
            if (pushin) begin
                dataout <= code_err ? '0 : DWIDTH'({y3, x5});
                kout    <= !code_err && k_flag;
                codeErr <= code_err;
                dispErr <= !code_err && (err6 || err4);
            end
        end
    end

    assign RDout = rd_reg;

endmodule
